// File: rtl/buzzer_pwm_dac_pkg.sv
// ============================================================================
// buzzer_pwm_dac_pkg : shared buzzer audio constants and volume attenuation
// Rev 1.0
// ============================================================================
`default_nettype none

package buzzer_pwm_dac_pkg;

  localparam int         c_pwm_bits_default = 8;
  localparam logic [7:0] c_silence_mid      = 8'h80;

  // Offset-binary sample scaled about the midpoint by an arithmetic right shift.
  function automatic logic [7:0] attenuate(input logic [7:0] s, input logic [2:0] vol);
    logic signed [8:0] d;
    logic signed [8:0] sh;
    d  = $signed({1'b0, s}) - 9'sd128;
    sh = d >>> vol;
    return c_silence_mid + sh[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/buzzer_pwm_dac_if.sv
// ============================================================================
// buzzer_pwm_dac_if : sample/control inputs and status outputs of the PWM DAC
// Rev 1.0
// ============================================================================
`default_nettype none

interface buzzer_pwm_dac_if #(
  parameter int DEPTH = 4
);
  localparam int c_lw = $clog2(DEPTH + 1);

  logic [15:0]     in_sample;
  logic            in_valid;
  logic            enable;
  logic [2:0]      volume;
  logic            clr_flags;
  logic            pwm_out;
  logic [c_lw-1:0] fifo_level;
  logic            full;
  logic            empty;
  logic            overflow;
  logic            underrun;

  modport master (
    output in_sample, in_valid, enable, volume, clr_flags,
    input  pwm_out, fifo_level, full, empty, overflow, underrun
  );

  modport slave (
    input  in_sample, in_valid, enable, volume, clr_flags,
    output pwm_out, fifo_level, full, empty, overflow, underrun
  );

endinterface

`default_nettype wire

// File: rtl/buzzer_pwm_dac_sample_fifo.sv
// ============================================================================
// buzzer_pwm_dac_sample_fifo : single-clock sample FIFO with flush and level
// Rev 1.0
// ============================================================================
`default_nettype none

module buzzer_pwm_dac_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH + 1)-1:0]   level
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_lw-1:0]  r_level;

  // A push while full is legal only when paired with a pop; the caller gates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      if (push && !pop)      r_level <= r_level + c_lw'(1);
      else if (pop && !push) r_level <= r_level - c_lw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign level = r_level;
  assign full  = (r_level == c_lw'(DEPTH));
  assign empty = (r_level == '0);

endmodule

`default_nettype wire

// File: rtl/buzzer_pwm_dac.sv
// ============================================================================
// buzzer_pwm_dac : buffered samples, volume attenuation, fixed-carrier PWM out
// Rev 1.0
// ============================================================================
`default_nettype none

module buzzer_pwm_dac
  import buzzer_pwm_dac_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter int         PWM_BITS = c_pwm_bits_default,
  parameter logic [7:0] SILENCE  = c_silence_mid
) (
  input logic             clk,
  input logic             rst,
  buzzer_pwm_dac_if.slave bus
);
  localparam int                  c_lw       = $clog2(DEPTH + 1);
  localparam logic [PWM_BITS-1:0] c_cnt_last = '1;

  logic [PWM_BITS-1:0] r_cnt;
  logic [7:0]          r_duty;
  logic                r_primed;
  logic                r_pwm;
  logic                r_overflow;
  logic                r_underrun;

  logic [7:0]          w_head;
  logic                w_full;
  logic                w_empty;
  logic [c_lw-1:0]     w_level;
  logic                w_boundary;
  logic                w_pop;
  logic                w_push;
  logic                w_ovf_set;
  logic                w_und_set;
  logic                w_cmp;
  logic                w_unused_low;

  assign w_unused_low = ^bus.in_sample[7:0];

  assign w_boundary = bus.enable && (r_cnt == c_cnt_last);
  assign w_pop      = w_boundary && !w_empty;
  // A boundary pop frees a slot in the same cycle, so a push into a full FIFO survives.
  assign w_push     = bus.in_valid && bus.enable && (!w_full || w_pop);
  assign w_ovf_set  = bus.in_valid && bus.enable && w_full && !w_pop;
  assign w_und_set  = w_boundary && w_empty && r_primed;
  assign w_cmp      = ({8'd0, r_cnt} < {{PWM_BITS{1'b0}}, r_duty});

  buzzer_pwm_dac_sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (!bus.enable),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (bus.in_sample[15:8]),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_duty   <= SILENCE;
      r_primed <= 1'b0;
      r_pwm    <= 1'b0;
    end else if (!bus.enable) begin
      r_cnt    <= '0;
      r_duty   <= SILENCE;
      r_primed <= 1'b0;
      r_pwm    <= 1'b0;
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
      r_pwm <= w_cmp;
      if (w_boundary) begin
        if (w_pop) begin
          r_duty   <= attenuate(w_head, bus.volume);
          r_primed <= 1'b1;
        end else begin
          r_duty   <= SILENCE;
          r_primed <= 1'b0;
        end
      end
    end
  end

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_ovf_set)          r_overflow <= 1'b1;
      else if (bus.clr_flags) r_overflow <= 1'b0;
      if (w_und_set)          r_underrun <= 1'b1;
      else if (bus.clr_flags) r_underrun <= 1'b0;
    end
  end

  assign bus.pwm_out    = r_pwm;
  assign bus.fifo_level = w_level;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.overflow   = r_overflow;
  assign bus.underrun   = r_underrun;

endmodule

`default_nettype wire
